ram_share_arb: RTL and testbench

- Single-clock controller that shares one dual-port RAM (8x16 by default; separate write and read address ports) between two requesters, R0 and R1.
- Arbitrates between them round-robin and issues exactly one RAM operation at a time through a small FSM.
- Sequences the RAM write/read strobes, returns read data with a valid pulse, and signals acceptance with a grant pulse.
- Sits between client logic and the RAM; all RAM-side outputs are registered.

---
 rtl/ram_share_arb.sv | 174 +++++++++++++++++
 tb/tb_ram_share_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_share_arb.sv
// ram_share_arb: shares one dual-port RAM between two requesters (R0, R1).
// One RAM operation is in flight at a time. Arbitration is round-robin by
// default. Define RAM_SHARE_ARB_FIXED_PRIO_EN to make R0 always win instead.
// All RAM-side outputs and status outputs are registered.
module ram_share_arb #(
  parameter int depth = 8,
  parameter int width = 16,
  parameter int addr  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             we0,
  input  logic [addr-1:0]  addr0,
  input  logic [width-1:0] wdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic [addr-1:0]  addr1,
  input  logic [width-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [width-1:0] rdata,
  output logic             busy,
  output logic             wr,
  output logic             rd,
  output logic [addr-1:0]  wraddr,
  output logic [addr-1:0]  rdaddr,
  output logic [width-1:0] din,
  input  logic [width-1:0] dout
);

  if (addr != $clog2(depth)) begin : g_addr_check
    $error("ram_share_arb: addr must equal clog2(depth)");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT
  } state_t;

  state_t state, state_nxt;

  // Requester that owns the operation in flight; steers the rvalid pulse.
  logic owner, owner_nxt;

`ifndef RAM_SHARE_ARB_FIXED_PRIO_EN
  // Last requester granted; the other one wins a tie.
  logic last, last_nxt;
`endif

  logic             any_req;
  logic             sel;
  logic             sel_we;
  logic [addr-1:0]  sel_addr;
  logic [width-1:0] sel_wdata;

  logic             gnt0_nxt, gnt1_nxt;
  logic             rvalid0_nxt, rvalid1_nxt;
  logic             wr_nxt, rd_nxt, busy_nxt;
  logic [width-1:0] rdata_nxt, din_nxt;
  logic [addr-1:0]  wraddr_nxt, rdaddr_nxt;

  // Pick the winning requester and mux its command.
  always_comb begin
    any_req = req0 | req1;
`ifdef RAM_SHARE_ARB_FIXED_PRIO_EN
    sel = ~req0;
`else
    sel = (req0 & req1) ? ~last : ~req0;
`endif
    sel_we    = sel ? we1    : we0;
    sel_addr  = sel ? addr1  : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
  end

  // State, pointer and all registered outputs; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
`ifndef RAM_SHARE_ARB_FIXED_PRIO_EN
      last    <= 1'b1;
`endif
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      wr      <= 1'b0;
      rd      <= 1'b0;
      busy    <= 1'b0;
      wraddr  <= '0;
      rdaddr  <= '0;
      din     <= '0;
      rdata   <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
`ifndef RAM_SHARE_ARB_FIXED_PRIO_EN
      last    <= last_nxt;
`endif
      gnt0    <= gnt0_nxt;
      gnt1    <= gnt1_nxt;
      rvalid0 <= rvalid0_nxt;
      rvalid1 <= rvalid1_nxt;
      wr      <= wr_nxt;
      rd      <= rd_nxt;
      busy    <= busy_nxt;
      wraddr  <= wraddr_nxt;
      rdaddr  <= rdaddr_nxt;
      din     <= din_nxt;
      rdata   <= rdata_nxt;
    end
  end

  // Next state: a read needs an extra cycle for the RAM data to return.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = rd ? RDWAIT : IDLE;
      RDWAIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes and pulses default low.
  always_comb begin
    gnt0_nxt    = 1'b0;
    gnt1_nxt    = 1'b0;
    rvalid0_nxt = 1'b0;
    rvalid1_nxt = 1'b0;
    wr_nxt      = 1'b0;
    rd_nxt      = 1'b0;
    busy_nxt    = (state_nxt != IDLE);
    wraddr_nxt  = wraddr;
    rdaddr_nxt  = rdaddr;
    din_nxt     = din;
    rdata_nxt   = rdata;
    owner_nxt   = owner;
`ifndef RAM_SHARE_ARB_FIXED_PRIO_EN
    last_nxt    = last;
`endif
    unique case (state)
      IDLE: begin
        if (any_req) begin
          gnt0_nxt  = ~sel;
          gnt1_nxt  = sel;
          owner_nxt = sel;
`ifndef RAM_SHARE_ARB_FIXED_PRIO_EN
          last_nxt  = sel;
`endif
          if (sel_we) begin
            wr_nxt     = 1'b1;
            wraddr_nxt = sel_addr;
            din_nxt    = sel_wdata;
          end else begin
            rd_nxt     = 1'b1;
            rdaddr_nxt = sel_addr;
          end
        end
      end
      RDWAIT: begin
        rdata_nxt   = dout;
        rvalid0_nxt = ~owner;
        rvalid1_nxt = owner;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_share_arb.sv
// tb_ram_share_arb: randomized scoreboard bench for ram_share_arb.
// A transaction-level model predicts the grant order and read data; a
// negedge monitor pops expectations whenever the DUT shows an operation.
module tb_ram_share_arb;

`ifdef RAM_SHARE_ARB_FIXED_PRIO_EN
  localparam bit fixedPrio = 1'b1;
`else
  localparam bit fixedPrio = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [2:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata;
  logic        busy, wr, rd;
  logic [2:0]  wraddr, rdaddr;
  logic [15:0] din;
  logic [15:0] dout = '0;

  ram_share_arb dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .wr(wr), .rd(rd),
    .wraddr(wraddr), .rdaddr(rdaddr), .din(din), .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dual-port RAM: registered read, one-cycle latency.
  logic [15:0] ramMem [8] = '{default: '0};
  always @(posedge clk) begin
    if (wr) ramMem[wraddr] <= din;
    if (rd) dout <= ramMem[rdaddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          who;
    bit          we;
    logic [2:0]  a;
    logic [15:0] d;
    bit          rv;
  } grantExp;

  typedef struct {
    bit          who;
    logic [15:0] d;
    int          cyc;
  } readExp;

  grantExp gq[$];
  readExp  rq[$];

  logic [15:0] modelMem [8] = '{default: '0};
  bit          modelLast = 1'b1;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model one served operation in service order and queue its expectation.
  task automatic modelOp(input bit who, input bit we, input logic [2:0] a, input logic [15:0] d, input bit rv);
    grantExp e;
    e.who = who;
    e.we  = we;
    e.a   = a;
    e.rv  = rv;
    if (we) begin
      e.d = d;
      modelMem[a] = d;
    end else begin
      e.d = modelMem[a];
    end
    modelLast = who;
    gq.push_back(e);
  endtask

  // Issue one command per selected requester, each held until its grant.
  task automatic applyStimulus(input bit r0, input bit w0, input logic [2:0] a0, input logic [15:0] d0,
                               input bit r1, input bit w1, input logic [2:0] a1, input logic [15:0] d1);
    bit pend0, pend1, first;
    int n;
    pend0 = r0;
    pend1 = r1;
    if (r0 && r1) first = fixedPrio ? 1'b0 : ~modelLast;
    else          first = r1 && !r0;
    if (first) begin
      modelOp(1'b1, w1, a1, d1, 1'b1);
      if (r0) modelOp(1'b0, w0, a0, d0, 1'b1);
    end else begin
      if (r0) modelOp(1'b0, w0, a0, d0, 1'b1);
      if (r1) modelOp(1'b1, w1, a1, d1, 1'b1);
    end
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    n = 0;
    while ((pend0 || pend1) && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (gnt0 && pend0) begin pend0 = 1'b0; req0 = 1'b0; end
      if (gnt1 && pend1) begin pend1 = 1'b0; req1 = 1'b0; end
    end
    checkOutput("grant_timeout", 32'({pend1, pend0}), 32'd0);
  endtask

  // Both requesters hold writes continuously for four grants.
  task automatic holdBoth();
    int grants;
    int n;
    bit who;
    for (int i = 0; i < 4; i++) begin
      who = fixedPrio ? 1'b0 : ~modelLast;
      modelOp(who, 1'b1, who ? 3'd3 : 3'd2, who ? 16'h2222 : 16'h1111, 1'b1);
    end
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd2; wdata0 = 16'h1111;
    req1 = 1'b1; we1 = 1'b1; addr1 = 3'd3; wdata1 = 16'h2222;
    grants = 0;
    n = 0;
    while (grants < 4 && n < 40) begin
      @(posedge clk); #1;
      n++;
      grants += int'(gnt0) + int'(gnt1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("hold_grants", grants, 32'd4);
  endtask

  // Monitor: match every operation and every rvalid pulse to the queues.
  grantExp ge;
  readExp  re;
  always @(negedge clk) begin
    if (rst && (gnt0 || gnt1 || wr || rd)) begin
      if (gq.size() == 0) begin
        checkOutput("unexpected_op", 32'({gnt1, gnt0, wr, rd}), 32'd0);
      end else begin
        ge = gq.pop_front();
        checkOutput("grant_who", 32'({gnt1, gnt0}), ge.who ? 32'd2 : 32'd1);
        checkOutput("strobes", 32'({wr, rd}), ge.we ? 32'd2 : 32'd1);
        checkOutput("busy_at_grant", 32'(busy), 32'd1);
        if (ge.we) begin
          checkOutput("wraddr", 32'(wraddr), 32'(ge.a));
          checkOutput("din", 32'(din), 32'(ge.d));
        end else begin
          checkOutput("rdaddr", 32'(rdaddr), 32'(ge.a));
          if (ge.rv) begin
            re.who = ge.who;
            re.d   = ge.d;
            re.cyc = cyc + 2;
            rq.push_back(re);
          end
        end
      end
    end
    if (rvalid0 || rvalid1) begin
      if (rq.size() == 0) begin
        checkOutput("unexpected_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      end else begin
        re = rq.pop_front();
        checkOutput("rvalid_who", 32'({rvalid1, rvalid0}), re.who ? 32'd2 : 32'd1);
        checkOutput("rdata", 32'(rdata), 32'(re.d));
        checkOutput("rvalid_latency", cyc, re.cyc);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: directed scenarios followed by a randomized phase.
  initial begin
    bit r0, r1;
    rst = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    @(posedge clk); #1;

    $display("[TB] reset with R0 requesting");
    fork
      applyStimulus(1'b1, 1'b1, 3'd0, 16'h1234, 1'b0, 1'b0, 3'd0, 16'h0);
      begin
        for (int i = 0; i < 2; i++) begin
          @(posedge clk); #1;
          checkOutput("reset_flags", 32'({gnt0, gnt1, rvalid0, rvalid1, wr, rd, busy}), 32'd0);
          checkOutput("reset_addrs", 32'({wraddr, rdaddr}), 32'd0);
          checkOutput("reset_din", 32'(din), 32'd0);
          checkOutput("reset_rdata", 32'(rdata), 32'd0);
        end
        rst = 1'b1;
      end
    join

    $display("[TB] R0 write A5A5 to addr 1");
    applyStimulus(1'b1, 1'b1, 3'd1, 16'hA5A5, 1'b0, 1'b0, 3'd0, 16'h0);
    @(posedge clk); #1;
    checkOutput("write_done_busy", 32'({busy, wr, gnt0}), 32'd0);

    $display("[TB] R1 read addr 1");
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd1, 16'h0);

    $display("[TB] both hold writes for four grants");
    holdBoth();

    $display("[TB] R0 read aborted by reset in RDWAIT");
    modelOp(1'b0, 1'b0, 3'd2, 16'h0, 1'b0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd2;
    for (int n = 0; n < 40 && !gnt0; n++) begin
      @(posedge clk); #1;
    end
    checkOutput("abort_grant_seen", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_flags", 32'({rvalid0, rvalid1, rd, busy}), 32'd0);
    checkOutput("abort_rdata", 32'(rdata), 32'd0);
    rst = 1'b1;
    modelLast = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_no_late_rvalid", 32'({rvalid0, rvalid1}), 32'd0);

    $display("[TB] R0 read and R1 write to addr 3 together");
    applyStimulus(1'b1, 1'b0, 3'd3, 16'h0, 1'b1, 1'b1, 3'd3, 16'h3333);
    applyStimulus(1'b1, 1'b0, 3'd3, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);

    $display("[TB] randomized phase");
    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      applyStimulus(r0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                    r1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
    end

    repeat (6) @(posedge clk);
    #1;
    checkOutput("grants_outstanding", gq.size(), 32'd0);
    checkOutput("reads_outstanding", rq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
